// File: rtl/model_checker.sv
// Buffers the clause stream and re-checks every clause against the solver's SAT model.
// Optional build macro MODEL_CHECK_FAIL_IDX_EN keeps the first-falsified-clause index register.
//
// state   | meaning
// COLLECT | accept clauses, wait for solver_ended
// CHECK   | evaluate one buffered clause per cycle
// DONE    | results frozen until clr or reset
module model_checker #(
  parameter int NUM_LIT     = 8,
  parameter int MAX_CLAUSES = 16,
  localparam int CW         = $clog2(MAX_CLAUSES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               cl_valid,
  output logic               cl_ready,
  input  logic [NUM_LIT-1:0] cl_pos,
  input  logic [NUM_LIT-1:0] cl_neg,
  input  logic               solver_ended,
  input  logic               solver_sat,
  input  logic [NUM_LIT-1:0] solver_model,
  output logic               chk_done,
  output logic               chk_pass,
  output logic               chk_skipped,
  output logic [CW-1:0]      chk_fail_idx,
  output logic [CW:0]        clause_cnt,
  output logic               overflow
);

  typedef enum logic [1:0] {COLLECT, CHECK, DONE} state_t;

  localparam logic [CW:0]   ONE  = (CW+1)'(1);
  localparam logic [CW:0]   FULL = (CW+1)'(MAX_CLAUSES);
  localparam logic [CW-1:0] IDX1 = CW'(1);

  state_t             state;
  logic [NUM_LIT-1:0] mem_pos [MAX_CLAUSES];
  logic [NUM_LIT-1:0] mem_neg [MAX_CLAUSES];
  logic [NUM_LIT-1:0] model_q;
  logic [CW-1:0]      rd_idx;
  logic               skip_q;
  logic               take;
  logic               ovf_now;
  logic               clause_sat;
  logic               last_clause;

  assign take        = (state == COLLECT) && cl_valid && cl_ready;
  assign ovf_now     = (state == COLLECT) && cl_valid && !cl_ready;
  assign clause_sat  = |((mem_pos[rd_idx] & model_q) | (mem_neg[rd_idx] & ~model_q));
  assign last_clause = (({1'b0, rd_idx} + ONE) == clause_cnt);

  // Storage is never cleared; clr and reset only rewind the count.
  always_ff @(posedge clock) begin
    if (take) begin
      mem_pos[clause_cnt[CW-1:0]] <= cl_pos;
      mem_neg[clause_cnt[CW-1:0]] <= cl_neg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      cl_ready    <= 1'b1;
      clause_cnt  <= '0;
      overflow    <= 1'b0;
      model_q     <= '0;
      rd_idx      <= '0;
      skip_q      <= 1'b0;
      chk_done    <= 1'b0;
      chk_pass    <= 1'b0;
      chk_skipped <= 1'b0;
`ifdef MODEL_CHECK_FAIL_IDX_EN
      chk_fail_idx <= '0;
`endif
    end else if (clr) begin
      state       <= COLLECT;
      cl_ready    <= 1'b1;
      clause_cnt  <= '0;
      overflow    <= 1'b0;
      rd_idx      <= '0;
      skip_q      <= 1'b0;
      chk_done    <= 1'b0;
      chk_pass    <= 1'b0;
      chk_skipped <= 1'b0;
`ifdef MODEL_CHECK_FAIL_IDX_EN
      chk_fail_idx <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (take) begin
            clause_cnt <= clause_cnt + ONE;
            cl_ready   <= (clause_cnt + ONE) < FULL;
          end
          if (ovf_now) overflow <= 1'b1;
          // Skipped verdicts still spend one CHECK cycle so every outcome has k >= 1.
          if (solver_ended) begin
            model_q  <= solver_model;
            rd_idx   <= '0;
            skip_q   <= !solver_sat || overflow || ovf_now;
            cl_ready <= 1'b0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (skip_q) begin
            state       <= DONE;
            chk_done    <= 1'b1;
            chk_skipped <= 1'b1;
            chk_pass    <= 1'b0;
          end else if (clause_cnt == '0) begin
            state    <= DONE;
            chk_done <= 1'b1;
            chk_pass <= 1'b1;
          end else if (!clause_sat) begin
            state    <= DONE;
            chk_done <= 1'b1;
            chk_pass <= 1'b0;
`ifdef MODEL_CHECK_FAIL_IDX_EN
            chk_fail_idx <= rd_idx;
`endif
          end else if (last_clause) begin
            state    <= DONE;
            chk_done <= 1'b1;
            chk_pass <= 1'b1;
          end else begin
            rd_idx <= rd_idx + IDX1;
          end
        end
        DONE: state <= DONE;
        default: state <= COLLECT;
      endcase
    end
  end

`ifndef MODEL_CHECK_FAIL_IDX_EN
  assign chk_fail_idx = '0;
`endif

endmodule

// File: tb/tb_model_checker.sv
// Directed bench for model_checker (NUM_LIT=4, MAX_CLAUSES=4) with a clause-list reference model.
module tb_model_checker;
  localparam int NL = 4;
  localparam int MC = 4;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          clr;
  logic          cl_valid;
  logic          cl_ready;
  logic [NL-1:0] cl_pos, cl_neg;
  logic          solver_ended, solver_sat;
  logic [NL-1:0] solver_model;
  logic          chk_done, chk_pass, chk_skipped, overflow;
  logic [CW-1:0] chk_fail_idx;
  logic [CW:0]   clause_cnt;

  int checks = 0;
  int errors = 0;

  model_checker #(.NUM_LIT(NL), .MAX_CLAUSES(MC)) dut (
    .clock(clock), .reset(reset), .clr(clr),
    .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_pos(cl_pos), .cl_neg(cl_neg),
    .solver_ended(solver_ended), .solver_sat(solver_sat), .solver_model(solver_model),
    .chk_done(chk_done), .chk_pass(chk_pass), .chk_skipped(chk_skipped),
    .chk_fail_idx(chk_fail_idx), .clause_cnt(clause_cnt), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit clause_ok(logic [NL-1:0] p, logic [NL-1:0] n, logic [NL-1:0] m);
    return ((p & m) != 0) || ((n & ~m) != 0);
  endfunction

  // Reference model: the clause list plus a verdict and its due edge.
  logic [NL-1:0] qp[$];
  logic [NL-1:0] qn[$];
  bit m_ovf = 0, m_ended = 0, m_skip = 0, m_pass = 0, m_fail = 0;
  int m_idx = 0, m_done_at = 0, edge_n = 0, k = 0;

  always @(posedge clock) begin
    edge_n++;
    if (!reset || clr) begin
      qp.delete(); qn.delete();
      m_ovf = 0; m_ended = 0;
    end else if (!m_ended) begin
      if (cl_valid) begin
        if (qp.size() < MC) begin qp.push_back(cl_pos); qn.push_back(cl_neg); end
        else m_ovf = 1;
      end
      if (solver_ended) begin
        m_ended = 1;
        m_skip  = !solver_sat || m_ovf;
        m_fail  = 0;
        m_idx   = 0;
        if (!m_skip)
          for (int i = 0; i < qp.size(); i++)
            if (!m_fail && !clause_ok(qp[i], qn[i], solver_model)) begin m_fail = 1; m_idx = i; end
        m_pass = !m_skip && !m_fail;
        if (m_skip || qp.size() == 0) k = 1;
        else if (m_fail) k = m_idx + 1;
        else k = qp.size();
        m_done_at = edge_n + k;
      end
    end
  end

  always @(negedge clock) begin
    bit d;
    int e_idx;
    if (!reset) begin
      check("rst_ready", cl_ready, 1);
      check("rst_done", chk_done, 0);
      check("rst_cnt", clause_cnt, 0);
    end else begin
      d = m_ended && (edge_n >= m_done_at);
`ifdef MODEL_CHECK_FAIL_IDX_EN
      e_idx = (d && m_fail) ? m_idx : 0;
`else
      e_idx = 0;
`endif
      check("m_ready", cl_ready, (!m_ended && qp.size() < MC) ? 1 : 0);
      check("m_cnt", clause_cnt, qp.size());
      check("m_ovf", overflow, m_ovf);
      check("m_done", chk_done, d);
      check("m_pass", chk_pass, d && m_pass);
      check("m_skip", chk_skipped, d && m_skip);
      check("m_idx", chk_fail_idx, e_idx);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic load(logic [NL-1:0] p, logic [NL-1:0] n);
    cl_valid = 1; cl_pos = p; cl_neg = n;
    tick();
    cl_valid = 0;
  endtask

  task automatic end_solver(bit sat, logic [NL-1:0] m);
    solver_ended = 1; solver_sat = sat; solver_model = m;
    tick();
    solver_ended = 0; cl_valid = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    tick();
    clr = 0;
    check("clr_ready", cl_ready, 1);
    check("clr_cnt", clause_cnt, 0);
    check("clr_done", chk_done, 0);
    check("clr_pass", chk_pass, 0);
    check("clr_skip", chk_skipped, 0);
    check("clr_ovf", overflow, 0);
  endtask

  task automatic expect_result(string name, int kk, int pass, int skip, int idx);
    repeat (kk - 1) tick();
    check({name, "_early"}, chk_done, 0);
    tick();
    check({name, "_done"}, chk_done, 1);
    check({name, "_pass"}, chk_pass, pass);
    check({name, "_skip"}, chk_skipped, skip);
`ifdef MODEL_CHECK_FAIL_IDX_EN
    check({name, "_idx"}, chk_fail_idx, idx);
`else
    check({name, "_idx"}, chk_fail_idx, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 0; clr = 0; cl_valid = 0; cl_pos = 0; cl_neg = 0;
    solver_ended = 0; solver_sat = 0; solver_model = 0;
    repeat (2) tick();
    check("init_ready", cl_ready, 1);
    check("init_ovf", overflow, 0);
    reset = 1;
    tick();

    // 1: both clauses satisfied
    load(4'b0001, 4'b0010);
    load(4'b0100, 4'b0000);
    check("t1_cnt", clause_cnt, 2);
    end_solver(1, 4'b0101);
    expect_result("t1", 2, 1, 0, 0);

    // 2: second clause falsified, then clr from DONE
    do_clr();
    load(4'b0001, 4'b0010);
    load(4'b0100, 4'b0000);
    end_solver(1, 4'b0001);
    expect_result("t2", 2, 0, 0, 1);
    tick();
    check("t2_hold", chk_done, 1);
    do_clr();

    // 3: UNSAT verdict
    load(4'b1000, 4'b0000);
    end_solver(0, 4'b1111);
    expect_result("t3", 1, 0, 1, 0);
    do_clr();

    // 4: overflow on the fifth back-to-back clause
    cl_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cl_pos = NL'(i + 1); cl_neg = 0;
      tick();
    end
    check("t4_ready", cl_ready, 0);
    check("t4_cnt4", clause_cnt, 4);
    tick();
    cl_valid = 0;
    check("t4_ovf", overflow, 1);
    check("t4_cnt", clause_cnt, 4);
    end_solver(1, 4'b1111);
    expect_result("t4", 1, 0, 1, 0);
    do_clr();

    // 5: nothing buffered
    end_solver(1, 4'b1010);
    expect_result("t5", 1, 1, 0, 0);
    do_clr();

    // 7: tautology clause, then empty clause accepted with solver_ended
    load(4'b0010, 4'b0010);
    cl_valid = 1; cl_pos = 4'b0000; cl_neg = 4'b0000;
    end_solver(1, 4'b0000);
    check("t7_cnt", clause_cnt, 2);
    expect_result("t7", 2, 0, 0, 1);
    do_clr();

    // 6: reset in the middle of CHECK, then a fresh run
    load(4'b0001, 4'b0000);
    load(4'b0010, 4'b0000);
    load(4'b0100, 4'b0000);
    end_solver(1, 4'b1111);
    tick();
    reset = 0;
    #1;
    check("t6_ready", cl_ready, 1);
    check("t6_cnt", clause_cnt, 0);
    check("t6_done", chk_done, 0);
    check("t6_pass", chk_pass, 0);
    tick();
    reset = 1;
    load(4'b0001, 4'b0010);
    load(4'b0100, 4'b0000);
    end_solver(1, 4'b0101);
    expect_result("t6", 2, 1, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
